// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg: mode encodings and default sizes shared
// by the CPU step-clock block and its button debouncer.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_STEP = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_RUN  = 2'b11
  } cpuMode_e;

  localparam int DEF_DEBOUNCE_SAMPLES = 4;
  localparam int DEF_COUNT_W          = 16;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus sample-tick debouncer
// for the board step button.
// Ports: clk50Mhz, reset (sync, active-high), stepBtn (raw),
//   sampTick (one-cycle debounce tick), btnState (debounced
//   level), btnRise (high the first cycle btnState reads 1).
module btn_debounce
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = DEF_DEBOUNCE_SAMPLES
) (
  input  logic clk50Mhz,
  input  logic reset,
  input  logic stepBtn,
  input  logic sampTick,
  output logic btnState,
  output logic btnRise
);

  localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_SAMPLES - 1);

  logic             btnMeta;
  logic             btnSync;
  logic             btnPrev;
  logic [CNT_W-1:0] sampCnt;

  always_ff @(posedge clk50Mhz) begin
    if (reset) begin
      btnMeta  <= 1'b0;
      btnSync  <= 1'b0;
      btnPrev  <= 1'b0;
      btnState <= 1'b0;
      sampCnt  <= '0;
    end else begin
      btnMeta <= stepBtn;
      btnSync <= btnMeta;
      btnPrev <= btnState;
      if (sampTick) begin
        // any disagreeing-then-agreeing sample restarts the run
        if (btnSync == btnState) begin
          sampCnt <= '0;
        end else if (sampCnt == CNT_LAST) begin
          btnState <= ~btnState;
          sampCnt  <= '0;
        end else begin
          sampCnt <= sampCnt + CNT_W'(1);
        end
      end
    end
  end

  assign btnRise = btnState & ~btnPrev;

endmodule

// File: rtl/cpu_step_clock.sv
// cpu_step_clock: one-cycle CPU clock enable in HALT, STEP,
// SLOW or RUN mode, all in the clk50Mhz domain.
// Ports: clk50Mhz, reset (sync, active-high), slowClk and
//   kindaSlowClk (divided clocks used as data), mode (switches),
//   stepBtn (raw button), cpuEn (step enable), stepCount
//   (wrapping pulse count), btnState (debounced button),
//   modeActive (synchronised mode in force).
module cpu_step_clock
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = DEF_DEBOUNCE_SAMPLES,
  parameter int COUNT_W          = DEF_COUNT_W
) (
  input  logic               clk50Mhz,
  input  logic               reset,
  input  logic               slowClk,
  input  logic               kindaSlowClk,
  input  logic [1:0]         mode,
  input  logic               stepBtn,
  output logic               cpuEn,
  output logic [COUNT_W-1:0] stepCount,
  output logic               btnState,
  output logic [1:0]         modeActive
);

  logic       slowPrev;
  logic       kindaPrev;
  logic       slowTick;
  logic       sampTick;
  logic       btnRise;
  logic [1:0] modeMeta;
  cpuMode_e   modeNow;

  assign slowTick = slowClk & ~slowPrev;
  assign sampTick = kindaSlowClk & ~kindaPrev;
  assign modeNow  = cpuMode_e'(modeActive);

  btn_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) uDebounce (
    .clk50Mhz(clk50Mhz),
    .reset   (reset),
    .stepBtn (stepBtn),
    .sampTick(sampTick),
    .btnState(btnState),
    .btnRise (btnRise)
  );

  always_ff @(posedge clk50Mhz) begin
    // history tracks the inputs even in reset so a level
    // already high at release is not seen as an edge
    slowPrev  <= slowClk;
    kindaPrev <= kindaSlowClk;
    if (reset) begin
      modeMeta   <= 2'b00;
      modeActive <= 2'b00;
      cpuEn      <= 1'b0;
      stepCount  <= '0;
    end else begin
      modeMeta   <= mode;
      modeActive <= modeMeta;
      stepCount  <= stepCount + COUNT_W'(cpuEn);
      unique case (modeNow)
        MODE_HALT: cpuEn <= 1'b0;
        MODE_STEP: cpuEn <= btnRise;
        MODE_SLOW: cpuEn <= slowTick;
        MODE_RUN:  cpuEn <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_clock.sv
// tb_cpu_step_clock: directed scoreboard bench for the
// CPU step-clock block.
module tb_cpu_step_clock;

  logic        clk50Mhz = 1'b0;
  logic        reset = 1'b1;
  logic        slowClk = 1'b0;
  logic        kindaSlowClk = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        stepBtn = 1'b0;
  logic        cpuEn;
  logic [15:0] stepCount;
  logic        btnState;
  logic [1:0]  modeActive;

  cpu_step_clock dut (
    .clk50Mhz    (clk50Mhz),
    .reset       (reset),
    .slowClk     (slowClk),
    .kindaSlowClk(kindaSlowClk),
    .mode        (mode),
    .stepBtn     (stepBtn),
    .cpuEn       (cpuEn),
    .stepCount   (stepCount),
    .btnState    (btnState),
    .modeActive  (modeActive)
  );

  always #10 clk50Mhz = ~clk50Mhz;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // enable-high cycles and enable rising edges, sampled mid-cycle
  int   enCount = 0;
  int   riseCount = 0;
  logic enQ = 1'b0;

  always @(negedge clk50Mhz) begin
    if (cpuEn === 1'b1) enCount++;
    if (cpuEn === 1'b1 && enQ !== 1'b1) riseCount++;
    enQ = cpuEn;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk50Mhz);
    #1;
  endtask

  task automatic expectVal(input string tag,
                           input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] exp,
                     input logic [31:0] obs);
    expectVal(tag, exp);
    compare(obs);
  endtask

  // one kindaSlowClk rising edge = one sample tick
  task automatic sampPulse(input int n);
    for (int i = 0; i < n; i++) begin
      kindaSlowClk = 1'b1;
      tick(2);
      kindaSlowClk = 1'b0;
      tick(2);
    end
  endtask

  int enBase;
  int riseBase;
  int cntBase;

  initial begin
    // reset with both divided clocks already high
    slowClk = 1'b1;
    kindaSlowClk = 1'b1;
    mode = 2'b10;
    reset = 1'b1;
    tick(2);
    chk("rst_cpuEn", 0, 32'(cpuEn));
    chk("rst_stepCount", 0, 32'(stepCount));
    chk("rst_btnState", 0, 32'(btnState));
    chk("rst_modeActive", 0, 32'(modeActive));
    reset = 1'b0;
    enBase = enCount;
    tick(10);
    chk("noTick_en", 0, 32'(enCount - enBase));
    chk("noTick_count", 0, 32'(stepCount));
    chk("slow_modeActive", 2, 32'(modeActive));

    // SLOW: three slowClk rising edges
    kindaSlowClk = 1'b0;
    enBase = enCount;
    riseBase = riseCount;
    for (int i = 0; i < 3; i++) begin
      slowClk = 1'b0;
      tick(50);
      slowClk = 1'b1;
      chk("slow_pre", 0, 32'(cpuEn));
      tick(1);
      chk("slow_pulse", 1, 32'(cpuEn));
      tick(1);
      chk("slow_post", 0, 32'(cpuEn));
      tick(48);
    end
    chk("slow_enCycles", 3, 32'(enCount - enBase));
    chk("slow_pulses", 3, 32'(riseCount - riseBase));
    chk("slow_count", 3, 32'(stepCount));

    // HALT ignores slow ticks
    mode = 2'b00;
    tick(3);
    enBase = enCount;
    slowClk = 1'b0;
    tick(5);
    slowClk = 1'b1;
    tick(5);
    chk("halt_en", 0, 32'(enCount - enBase));

    // STEP: three short bounces, never 4 agreeing samples
    mode = 2'b01;
    tick(3);
    chk("step_modeActive", 1, 32'(modeActive));
    enBase = enCount;
    cntBase = stepCount;
    for (int b = 0; b < 3; b++) begin
      stepBtn = 1'b1;
      tick(3);
      sampPulse(2);
      stepBtn = 1'b0;
      tick(3);
      sampPulse(1);
    end
    chk("bounce_btn", 0, 32'(btnState));
    chk("bounce_en", 0, 32'(enCount - enBase));

    // stable press: state flips on the 4th agreeing tick
    stepBtn = 1'b1;
    tick(3);
    sampPulse(3);
    chk("press3_btn", 0, 32'(btnState));
    kindaSlowClk = 1'b1;
    tick(1);
    chk("press4_btn", 1, 32'(btnState));
    chk("press4_en", 0, 32'(cpuEn));
    tick(1);
    chk("press_pulse", 1, 32'(cpuEn));
    tick(1);
    chk("press_post", 0, 32'(cpuEn));
    kindaSlowClk = 1'b0;
    tick(2);
    sampPulse(20);
    chk("hold_en", 1, 32'(enCount - enBase));
    chk("hold_count", 32'(cntBase + 1), 32'(stepCount));
    chk("hold_btn", 1, 32'(btnState));

    // re-enter STEP with button already high
    mode = 2'b10;
    tick(3);
    mode = 2'b01;
    tick(3);
    chk("reenter_en", 1, 32'(enCount - enBase));
    stepBtn = 1'b0;
    tick(3);
    sampPulse(4);
    chk("release_btn", 0, 32'(btnState));
    chk("release_en", 1, 32'(enCount - enBase));
    stepBtn = 1'b1;
    tick(3);
    sampPulse(4);
    tick(3);
    chk("repress_en", 2, 32'(enCount - enBase));
    chk("repress_count", 32'(cntBase + 2), 32'(stepCount));

    // RUN from reset: mode sync (2) + enable register (1)
    // means 70000 edges after release give 69997 pulses
    mode = 2'b11;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    enBase = enCount;
    tick(70000);
    chk("run_en", 69997, 32'(enCount - enBase));
    chk("run_wrap", 32'(69997 % 65536), 32'(stepCount));
    chk("run_cpuEn", 1, 32'(cpuEn));

    // reach 0x1234 with a debounced press, then reset
    stepBtn = 1'b1;
    tick(3);
    sampPulse(4);
    tick(32'h1234 - 4461 - 19);
    chk("pre_rst_count", 32'h1234, 32'(stepCount));
    chk("pre_rst_btn", 1, 32'(btnState));
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midrst_cpuEn", 0, 32'(cpuEn));
    chk("midrst_count", 0, 32'(stepCount));
    chk("midrst_mode", 0, 32'(modeActive));
    chk("midrst_btn", 0, 32'(btnState));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
